// File: rtl/hifp_lsu_rtl_function_if.sv
// Kernel-pipeline and Avalon bus bundle for hifp_lsu_rtl_function.
// master: the LSU stage itself; slave: upstream/downstream pipeline and memory.
interface hifp_lsu_rtl_function_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32,
    parameter int ELEM_W = 16
);
    logic                  m_valid_in;
    logic                  m_ready_out;
    logic [31:0]           m_input_wave;
    logic [31:0]           m_input_fpid;
    logic [ELEM_W-1:0]     m_output_0;
    logic                  m_valid_out;
    logic                  m_ready_in;
    logic                  m_start;
    logic [ADDR_W-1:0]     avm_ld_address;
    logic                  avm_ld_read;
    logic                  avm_ld_waitrequest;
    logic [DATA_W-1:0]     avm_ld_readdata;
    logic                  avm_ld_readdatavalid;
    logic [4:0]            avm_ld_burstcount;
    logic [ADDR_W-1:0]     avm_st_address;
    logic                  avm_st_write;
    logic                  avm_st_waitrequest;
    logic [DATA_W-1:0]     avm_st_writedata;
    logic [DATA_W/8-1:0]   avm_st_byteenable;
    logic                  avm_st_writeack;
    logic [4:0]            avm_st_burstcount;
    logic [31:0]           items_done;
    logic                  has_a_write_pending;
    logic                  has_a_lsu_active;

    modport master (
        input  m_valid_in, m_input_wave, m_input_fpid, m_ready_in, m_start,
        input  avm_ld_waitrequest, avm_ld_readdata, avm_ld_readdatavalid,
        input  avm_st_waitrequest, avm_st_writeack,
        output m_ready_out, m_output_0, m_valid_out,
        output avm_ld_address, avm_ld_read, avm_ld_burstcount,
        output avm_st_address, avm_st_write, avm_st_writedata,
        output avm_st_byteenable, avm_st_burstcount,
        output items_done, has_a_write_pending, has_a_lsu_active
    );

    modport slave (
        output m_valid_in, m_input_wave, m_input_fpid, m_ready_in, m_start,
        output avm_ld_waitrequest, avm_ld_readdata, avm_ld_readdatavalid,
        output avm_st_waitrequest, avm_st_writeack,
        input  m_ready_out, m_output_0, m_valid_out,
        input  avm_ld_address, avm_ld_read, avm_ld_burstcount,
        input  avm_st_address, avm_st_write, avm_st_writedata,
        input  avm_st_byteenable, avm_st_burstcount,
        input  items_done, has_a_write_pending, has_a_lsu_active
    );
endinterface

// File: rtl/hifp_lsu_rtl_function.sv
// Single-item LSU stage: loads element [wave], optionally stores it to [fpid].
// Ports: clock, resetn (sync, active-low), bus (master modport of the _if).
module hifp_lsu_rtl_function #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32,
    parameter int ELEM_W = 16,
    parameter int MODE   = 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    hifp_lsu_rtl_function_if.master bus
);
    localparam int EB    = ELEM_W / 8;
    localparam int LB    = DATA_W / 8;
    localparam int EBW   = $clog2(EB);
    localparam int LANES = DATA_W / ELEM_W;
    localparam int LNW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] LMASK = ~ADDR_W'(LB - 1);
    localparam logic [LB-1:0]     BE0   = LB'((1 << EB) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_ACK, S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_wave;
    logic [31:0]       r_fpid;
    logic [ELEM_W-1:0] r_elem;
    logic [31:0]       r_done;
    logic              r_lsu;
    logic              r_wpend;
    logic [ADDR_W-1:0] w_wave_ba;
    logic [ADDR_W-1:0] w_fpid_ba;
    logic [LNW-1:0]    w_wave_lane;
    logic [LNW-1:0]    w_fpid_lane;
    logic              w_done;

    // Index to byte address; the widened shift keeps bits above 32 when ADDR_W > 32.
    function automatic logic [ADDR_W-1:0] f_ba(input logic [31:0] idx);
        logic [63:0] v;
        v = {32'b0, idx} << EBW;
        return v[ADDR_W-1:0];
    endfunction

    function automatic logic [LNW-1:0] f_lane(input logic [ADDR_W-1:0] ba);
        logic [ADDR_W-1:0] v;
        v = (ba & ADDR_W'(LB - 1)) >> EBW;
        return v[LNW-1:0];
    endfunction

    assign w_wave_ba   = f_ba(r_wave);
    assign w_fpid_ba   = f_ba(r_fpid);
    assign w_wave_lane = f_lane(w_wave_ba);
    assign w_fpid_lane = f_lane(w_fpid_ba);
    assign w_done      = (r_state == S_OUT) && bus.m_ready_in;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.m_valid_in) w_next = S_RD_REQ;
            S_RD_REQ:  if (!bus.avm_ld_waitrequest) w_next = S_RD_WAIT;
            S_RD_WAIT: if (bus.avm_ld_readdatavalid)
                           w_next = (MODE == 1) ? S_WR_REQ : S_OUT;
            S_WR_REQ:  if (!bus.avm_st_waitrequest) w_next = S_WR_ACK;
            S_WR_ACK:  if (bus.avm_st_writeack) w_next = S_OUT;
            S_OUT:     if (bus.m_ready_in) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_wave  <= '0;
            r_fpid  <= '0;
            r_elem  <= '0;
            r_done  <= '0;
            r_lsu   <= 1'b0;
            r_wpend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.m_valid_in) begin
                r_wave <= bus.m_input_wave;
                r_fpid <= bus.m_input_fpid;
            end
            if (r_state == S_RD_WAIT && bus.avm_ld_readdatavalid)
                r_elem <= bus.avm_ld_readdata[w_wave_lane*ELEM_W +: ELEM_W];
            r_lsu   <= (w_next == S_RD_REQ) || (w_next == S_RD_WAIT) ||
                       (w_next == S_WR_REQ) || (w_next == S_WR_ACK);
            r_wpend <= (w_next == S_WR_REQ) || (w_next == S_WR_ACK);
            // A start landing on a completion counts that completion.
            if (bus.m_start)
                r_done <= w_done ? 32'd1 : 32'd0;
            else if (w_done)
                r_done <= r_done + 32'd1;
        end
    end

    // Gated by resetn so nothing is offered while reset is held.
    assign bus.m_ready_out       = resetn && (r_state == S_IDLE);
    assign bus.m_valid_out       = (r_state == S_OUT);
    assign bus.m_output_0        = r_elem;
    assign bus.avm_ld_read       = (r_state == S_RD_REQ);
    assign bus.avm_ld_address    = w_wave_ba & LMASK;
    assign bus.avm_ld_burstcount = 5'd1;
    assign bus.avm_st_write      = (r_state == S_WR_REQ);
    assign bus.avm_st_address    = w_fpid_ba & LMASK;
    assign bus.avm_st_writedata  = {LANES{r_elem}};
    assign bus.avm_st_byteenable = (r_state == S_WR_REQ) ?
                                   (BE0 << (w_fpid_lane * EB)) : '0;
    assign bus.avm_st_burstcount = 5'd1;
    assign bus.items_done        = r_done;
    assign bus.has_a_lsu_active  = r_lsu;
    assign bus.has_a_write_pending = r_wpend;
endmodule

// File: doc/hifp_lsu_rtl_function.md
Name: hifp_lsu_rtl_function

Overview:
- Parametrised successor to the HIFP RTL-function stub; drops into an OpenCL kernel pipeline as a stall-aware valid/ready stage.
- Each work-item carries an element index (wave) and a destination index (fpid).
- The block loads one ELEM_W element from local memory over the Avalon load port, optionally stores it to fpid over the store port, then returns it on m_output_0.
- One work-item in flight at a time. LSU-activity flags feed the kernel's drain logic.

Parameters:
- DATA_W, 512: Avalon data width in bits. Power of two, at least ELEM_W.
- ADDR_W, 32: Avalon byte-address width.
- ELEM_W, 16: element width in bits. One of 8, 16, 32 or 64.
- MODE, 1: 0 = load only; 1 = load then store to fpid.

Ports:
- clock in 1: single clock.
- resetn in 1: synchronous, active-low reset.
- m_valid_in in 1: upstream valid.
- m_ready_out out 1: ready to accept a work-item.
- m_input_wave in 32: source element index.
- m_input_fpid in 32: destination element index.
- m_output_0 out ELEM_W: loaded element.
- m_valid_out out 1: result valid.
- m_ready_in in 1: downstream ready.
- m_start in 1: kernel start pulse; clears items_done.
- avm_ld_address out ADDR_W: load port line-aligned byte address.
- avm_ld_read out 1: load port read request.
- avm_ld_waitrequest in 1: load port stall.
- avm_ld_readdata in DATA_W: load port read data.
- avm_ld_readdatavalid in 1: load port read data valid.
- avm_ld_burstcount out 5: fixed at 1.
- avm_st_address out ADDR_W: store port line-aligned byte address.
- avm_st_write out 1: store port write request.
- avm_st_waitrequest in 1: store port stall.
- avm_st_writedata out DATA_W: store port write data.
- avm_st_byteenable out DATA_W/8: store port byte enables.
- avm_st_writeack in 1: store port write acknowledge.
- avm_st_burstcount out 5: fixed at 1.
- items_done out 32: count of work-items completed since m_start.
- has_a_write_pending out 1: a store is issued but not yet acknowledged.
- has_a_lsu_active out 1: any memory operation is in progress.

Behaviour:
- Reset: while resetn=0 at a clock edge, the FSM goes to IDLE and all outputs clear to 0.
  - This includes m_output_0, items_done, both flags and all Avalon requests.
  - Burstcount outputs are constant 1 and are not affected by reset.
  - Reset mid-transaction abandons the transaction. Late readdatavalid or writeack after reset is ignored in IDLE.
- Derived constants: EB = ELEM_W/8, LB = DATA_W/8.
- Address arithmetic:
  - byte address = index*EB, truncated to ADDR_W.
  - Line address = byte address with its low log2(LB) bits forced to 0.
  - lane = byte address[log2(LB)-1 : log2(EB)].
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_ACK, OUT.
- IDLE:
  - m_ready_out=1; it is 0 in every other state.
  - On m_valid_in=1, latch wave and fpid and go to RD_REQ.
- RD_REQ:
  - avm_ld_read=1 with the line address of wave.
  - Hold until waitrequest=0, then go to RD_WAIT.
- RD_WAIT:
  - On readdatavalid=1, capture lane `lane` of readdata into m_output_0.
  - Next state is WR_REQ if MODE=1, otherwise OUT.
  - readdatavalid seen in any state other than RD_WAIT is ignored.
- WR_REQ:
  - avm_st_write=1 with the line address of fpid.
  - writedata = element replicated across all lanes.
  - byteenable = EB ones at byte offset lane(fpid)*EB, zeros elsewhere.
  - Hold until waitrequest=0, then go to WR_ACK.
- WR_ACK: wait for writeack=1, then go to OUT.
- OUT:
  - m_valid_out=1 and m_output_0 held stable.
  - On m_ready_in=1, go to IDLE and increment items_done (wraps at 2^32).
- Flags (registered, derived from the next state):
  - has_a_lsu_active = 1 in RD_REQ, RD_WAIT, WR_REQ and WR_ACK.
  - has_a_write_pending = 1 in WR_REQ and WR_ACK.
- Latency with no stalls and read latency L≥1:
  - Accept at cycle T; read issued at T+1; data captured at T+1+L.
  - MODE=0: m_valid_out at T+2+L.
  - MODE=1: write issued at T+2+L. With writeack latency A, m_valid_out at T+3+L+A.
- Simultaneous events:
  - If m_start and an OUT completion occur in the same cycle, items_done becomes 1.
  - Otherwise m_start sets items_done to 0 and does not affect the FSM.
- m_valid_in while busy is not accepted, because m_ready_out=0.

Test Plan:
- Reset with MODE=1: wave=3, fpid=5. Readdata lane 3 = 0xBEEF; no stalls, L=2, A=1.
  - ld address 0x0, st address 0x0.
  - byteenable = 0xC00 (bytes 10 and 11).
  - m_output_0 = 0xBEEF, items_done = 1.
- Line crossing: wave=32 with ELEM_W=16, DATA_W=512 -> ld address 0x40, lane 0.
- Stalls: ld waitrequest held 4 cycles, then m_ready_in low 3 cycles.
  - read and address held stable throughout; has_a_lsu_active=1 until WR_ACK exits.
  - m_output_0 held during OUT; exactly one write issued.
- MODE=0: has_a_write_pending never asserts; avm_st_write stays 0; m_valid_out at T+2+L.
- Reset mid-read, then assert readdatavalid -> FSM stays in IDLE, m_valid_out stays 0, all flags 0.
- m_start in the same cycle as an OUT completion -> items_done = 1; a subsequent lone m_start -> items_done = 0.
